mem_fill_responder: RTL and testbench

- Main-memory-side responder for the cache replacement path.
- Answers the cache's memory chip-select (mem_sel) with either a block-fill read burst or a single-word write-through.
- Holds a synthesizable word-addressed backing array and applies a fixed access latency.
- Drives wait_req back to the cache controller/replacer while a transaction is in progress.

---
 rtl/mem_fill_if.sv | 24 ++
 rtl/mem_fill_responder.sv | 117 +++++++++++
 tb/tb_mem_fill_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_if.sv
// Cache-to-memory request/response bundle for the block-fill and write-through path.
interface mem_fill_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_sel;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  burst_last;
    logic                  wait_req;

    modport master (
        output mem_sel, we, addr, wdata,
        input  rdata, rvalid, burst_last, wait_req
    );

    modport slave (
        input  mem_sel, we, addr, wdata,
        output rdata, rvalid, burst_last, wait_req
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Main-memory responder: block-fill read bursts after a fixed latency, single-word
// write-through, word-addressed backing array with modulo aliasing.
module mem_fill_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 4,
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 4
) (
    input  logic     clk,
    input  logic     rst,
    mem_fill_if.slave bus
);
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int WPB    = BLOCK_SIZE / BPW;
    localparam int OFF    = $clog2(BPW);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int BEAT_W = (WPB > 1) ? $clog2(WPB) : 1;

    localparam logic [IDX_W-1:0]  BLOCK_MASK = IDX_W'(WPB - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WPB - 1);

    typedef enum logic [1:0] {IDLE, LATENCY, BURST, WRITE} state_t;

    state_t            state, state_next;
    logic [LAT_W-1:0]  lat, lat_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [IDX_W-1:0]  base, base_next;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_next;
    logic [IDX_W-1:0]  word_idx, rd_idx;
    logic              rd_en, mem_we;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Sub-word and high address bits are deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr;

    assign word_idx = bus.addr[OFF +: IDX_W];

    // NOTE: every signal written here gets a default first so no branch can infer a latch.
    always_comb begin
        state_next = state;
        lat_next   = lat;
        beat_next  = beat;
        base_next  = base;
        rdata_next = '0;
        rd_en      = 1'b0;
        rd_idx     = '0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_sel) begin
                    if (bus.we) begin
                        mem_we     = 1'b1;
                        state_next = WRITE;
                    end else begin
                        base_next  = word_idx & ~BLOCK_MASK;
                        lat_next   = LAT_LOAD;
                        state_next = LATENCY;
                    end
                end
            end
            LATENCY: begin
                if (lat == '0) begin
                    state_next = BURST;
                    beat_next  = '0;
                    rd_en      = 1'b1;
                    rd_idx     = base;
                end else begin
                    lat_next = lat - LAT_W'(1);
                end
            end
            BURST: begin
                // beat names the word currently on rdata; prefetch the next one into the register.
                if (beat == LAST_BEAT) begin
                    state_next = IDLE;
                end else begin
                    beat_next = beat + BEAT_W'(1);
                    rd_en     = 1'b1;
                    rd_idx    = base + IDX_W'(beat_next);
                end
            end
            WRITE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rd_en) rdata_next = mem[rd_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat     <= '0;
            beat    <= '0;
            base    <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            lat     <= lat_next;
            beat    <= beat_next;
            base    <= base_next;
            rdata_q <= rdata_next;
        end
    end

    // NOTE: the backing array has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= bus.wdata;
    end

    assign bus.rdata      = rdata_q;
    assign bus.rvalid     = (state == BURST);
    assign bus.burst_last = (state == BURST) && (beat == LAST_BEAT);
    assign bus.wait_req   = (state != IDLE);
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench: three responder configurations share one stimulus set selected by tgt.
module tb_mem_fill_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    int          tgt = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] o_rdata;
    logic        o_rvalid, o_last, o_wait;

    always #5 clk = ~clk;

    mem_fill_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
    mem_fill_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();
    mem_fill_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_c ();

    // A: WPB=1, L=4, 256 words.  B: WPB=4, L=3, 16 words.  C: WPB=4, L=2, 256 words.
    mem_fill_responder #(.BLOCK_SIZE(4), .MEM_WORDS(256), .READ_LATENCY(4))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mem_fill_responder #(.BLOCK_SIZE(16), .MEM_WORDS(16), .READ_LATENCY(3))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    mem_fill_responder #(.BLOCK_SIZE(16), .MEM_WORDS(256), .READ_LATENCY(2))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.mem_sel = (tgt == 0) ? mem_sel : 1'b0;
    assign if_b.mem_sel = (tgt == 1) ? mem_sel : 1'b0;
    assign if_c.mem_sel = (tgt == 2) ? mem_sel : 1'b0;
    assign if_a.we = we;  assign if_b.we = we;  assign if_c.we = we;
    assign if_a.addr = addr;  assign if_b.addr = addr;  assign if_c.addr = addr;
    assign if_a.wdata = wdata;  assign if_b.wdata = wdata;  assign if_c.wdata = wdata;

    always_comb begin
        case (tgt)
            0: begin o_rdata = if_a.rdata; o_rvalid = if_a.rvalid; o_last = if_a.burst_last; o_wait = if_a.wait_req; end
            1: begin o_rdata = if_b.rdata; o_rvalid = if_b.rvalid; o_last = if_b.burst_last; o_wait = if_b.wait_req; end
            default: begin o_rdata = if_c.rdata; o_rvalid = if_c.rvalid; o_last = if_c.burst_last; o_wait = if_c.wait_req; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        mem_sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        check("wr_wait_hi", o_wait, 1);
        mem_sel = 1'b0; we = 1'b0;
        tick();
        check("wr_wait_lo", o_wait, 0);
        check("wr_no_rvalid", o_rvalid, 0);
    endtask

    // Check one post-edge cycle: expected rvalid/last/wait and, when valid, the data word.
    task automatic expect_cycle(input string tag, input logic ev, input logic el,
                                input logic ew, input logic [31:0] ed);
        check({tag, "_rvalid"}, o_rvalid, ev);
        check({tag, "_last"}, o_last, el);
        check({tag, "_wait"}, o_wait, ew);
        check({tag, "_rdata"}, o_rdata, ev ? ed : 32'h0);
    endtask

    initial begin
        logic [31:0] a_words [4];
        logic [31:0] c_words [4];
        a_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        c_words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};

        // Reset state of all three instances.
        tick(); tick();
        for (int t = 0; t < 3; t++) begin
            tgt = t; #1;
            expect_cycle("reset", 0, 0, 0, 0);
        end
        rst = 1'b0;

        // A: single-word write then read, L=4, WPB=1.
        tgt = 0; #1;
        do_write(32'h10, 32'hDEADBEEF);
        mem_sel = 1'b1; we = 1'b0; addr = 32'h10;
        tick();
        expect_cycle("a_accept", 0, 0, 1, 0);
        mem_sel = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 4)       expect_cycle("a_lat", 0, 0, 1, 0);
            else if (k == 4) expect_cycle("a_beat", 1, 1, 1, 32'hDEADBEEF);
            else             expect_cycle("a_idle", 0, 0, 0, 0);
        end

        // B: preload words 4..7, read 0x1C -> aligned base word 4, L=3.
        tgt = 1; #1;
        for (int i = 0; i < 4; i++) do_write(32'h10 + 32'(4 * i), a_words[i]);
        mem_sel = 1'b1; we = 1'b0; addr = 32'h1C;
        tick();
        expect_cycle("b_accept", 0, 0, 1, 0);
        mem_sel = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 3)       expect_cycle("b_lat", 0, 0, 1, 0);
            else if (k <= 6) expect_cycle("b_beat", 1, k == 6, 1, a_words[k-3]);
            else             expect_cycle("b_idle", 0, 0, 0, 0);
        end

        // B: address wrap, 0x40 -> word 0 and 0x44 -> word 1 on a 16-word array.
        do_write(32'h40, 32'h55);
        do_write(32'h44, 32'h66);

        // B: held request, with we/addr/wdata disturbed mid-burst.
        mem_sel = 1'b1; we = 1'b0; addr = 32'h10;
        tick();
        expect_cycle("h_accept", 0, 0, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k <= 2)       expect_cycle("h_lat1", 0, 0, 1, 0);
            else if (k <= 6)  expect_cycle("h_beat1", 1, k == 6, 1, a_words[k-3]);
            else if (k == 7)  expect_cycle("h_gap", 0, 0, 0, 0);
            else if (k <= 10) expect_cycle("h_lat2", 0, 0, 1, 0);
            else if (k <= 14) expect_cycle("h_beat2", 1, k == 14, 1, a_words[k-11]);
            else              expect_cycle("h_idle", 0, 0, 0, 0);
            if (k == 1) begin we = 1'b1; addr = 32'h0; wdata = 32'hBAD; end
            if (k == 6) begin we = 1'b0; addr = 32'h10; end
            if (k == 14) mem_sel = 1'b0;
        end

        // B: read 0x00 returns the aliased writes, untouched by the disturbed held request.
        mem_sel = 1'b1; we = 1'b0; addr = 32'h0;
        tick();
        mem_sel = 1'b0;
        tick(); tick(); tick();
        expect_cycle("wrap_w0", 1, 0, 1, 32'h55);
        tick();
        expect_cycle("wrap_w1", 1, 0, 1, 32'h66);
        tick(); tick(); tick();
        expect_cycle("wrap_idle", 0, 0, 0, 0);

        // C: reset asserted asynchronously after the second beat, L=2.
        tgt = 2; #1;
        for (int i = 0; i < 4; i++) do_write(32'(4 * i), c_words[i]);
        mem_sel = 1'b1; we = 1'b0; addr = 32'h0;
        tick();
        mem_sel = 1'b0;
        tick();
        expect_cycle("r_lat", 0, 0, 1, 0);
        tick();
        expect_cycle("r_beat0", 1, 0, 1, 32'hC0);
        tick();
        expect_cycle("r_beat1", 1, 0, 1, 32'hC1);
        #2 rst = 1'b1;
        #1 expect_cycle("r_async", 0, 0, 0, 0);
        tick(); tick();
        expect_cycle("r_held", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        expect_cycle("r_after", 0, 0, 0, 0);
        mem_sel = 1'b1; we = 1'b0; addr = 32'h8;
        tick();
        mem_sel = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 2)       expect_cycle("r2_lat", 0, 0, 1, 0);
            else if (k <= 5) expect_cycle("r2_beat", 1, k == 5, 1, c_words[k-2]);
            else             expect_cycle("r2_idle", 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
